bk_ay_seq: RTL

BK_AY_SEQ -- requirements
Module: bk_ay_seq

---
 rtl/bk_ay_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bk_ay_seq.sv
// Bus sequencer for up to four AY-3-8910 PSGs sharing one DA bus.
// Each transfer latches the register address (BDIR/BC1/BC2) and then writes or reads it.
// A per-chip cache of the last latched address lets repeat accesses skip the latch phase.
module bk_ay_seq #(
    parameter int NCHIPS   = 2,
    parameter int ADDR_CYC = 2,
    parameter int DATA_CYC = 3,
    parameter int GAP_CYC  = 1,
    parameter int CACHE_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        chip,
    input  logic [3:0]        reg_a,
    input  logic [7:0]        wdata,
    input  logic              flush,
    output logic              ready,
    output logic              done,
    output logic [7:0]        rdata,
    output logic [NCHIPS-1:0] bdir,
    output logic [NCHIPS-1:0] bc1,
    output logic [NCHIPS-1:0] bc2,
    output logic [7:0]        da_out,
    output logic              da_oe,
    input  logic [7:0]        da_in
);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP1, S_XFER, S_GAP2} state_t;

    localparam logic [7:0] ADDR_LAST = 8'(ADDR_CYC - 1);
    localparam logic [7:0] DATA_LAST = 8'(DATA_CYC - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [2:0] NCH       = 3'(NCHIPS);

    state_t            state, nxt_state;
    logic [7:0]        cnt, nxt_cnt;
    logic              we_q, nxt_we;
    logic [1:0]        chip_q, nxt_chip;
    logic [3:0]        reg_q, nxt_reg;
    logic [7:0]        wdata_q, nxt_wdata;
    logic [3:0]        cache_addr [4];
    logic [3:0]        cache_vld;
    logic              is_null, hit, latch_end, nxt_done;
    logic [7:0]        nxt_rdata;
    logic [NCHIPS-1:0] sel, nxt_bdir, nxt_bc1;
    logic              nxt_oe;
    logic [7:0]        nxt_dout;

    // Request classification: out-of-range chip, or cached address (flush forces a miss)
    always_comb begin
        is_null   = ({1'b0, chip} >= NCH);
        hit       = (CACHE_EN != 0) && !flush && cache_vld[chip] && (cache_addr[chip] == reg_a);
        latch_end = (state == S_LATCH) && (cnt == ADDR_LAST);
    end

    // Next-state, phase counter, captured request and completion decode
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_we    = we_q;
        nxt_chip  = chip_q;
        nxt_reg   = reg_q;
        nxt_wdata = wdata_q;
        nxt_done  = 1'b0;
        nxt_rdata = rdata;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (is_null) begin
                        // Nothing on the bus; complete immediately, reads return all ones
                        nxt_done = 1'b1;
                        if (!we) nxt_rdata = 8'hFF;
                    end else begin
                        nxt_we    = we;
                        nxt_chip  = chip;
                        nxt_reg   = reg_a;
                        nxt_wdata = wdata;
                        nxt_cnt   = 8'd0;
                        nxt_state = hit ? S_XFER : S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                if (cnt == ADDR_LAST) begin
                    nxt_state = S_GAP1;
                    nxt_cnt   = 8'd0;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            S_GAP1: begin
                if (cnt == GAP_LAST) begin
                    nxt_state = S_XFER;
                    nxt_cnt   = 8'd0;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            S_XFER: begin
                if (cnt == DATA_LAST) begin
                    if (!we_q) nxt_rdata = da_in;
                    nxt_state = S_GAP2;
                    nxt_cnt   = 8'd0;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            S_GAP2: begin
                if (cnt == GAP_LAST) begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = 8'd0;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_cnt = cnt + 8'd1;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_cnt   = 8'd0;
            end
        endcase
    end

    // Bus pattern for the state being entered, so the registered outputs line up with it
    always_comb begin
        sel = '0;
        for (int i = 0; i < NCHIPS; i++) sel[i] = (nxt_chip == 2'(i));
        nxt_bdir = '0;
        nxt_bc1  = '0;
        nxt_oe   = 1'b0;
        nxt_dout = 8'h00;
        case (nxt_state)
            S_LATCH: begin
                nxt_bdir = sel;
                nxt_bc1  = sel;
                nxt_oe   = 1'b1;
                nxt_dout = {4'h0, nxt_reg};
            end
            S_XFER: begin
                if (nxt_we) begin
                    nxt_bdir = sel;
                    nxt_oe   = 1'b1;
                    nxt_dout = nxt_wdata;
                end else begin
                    nxt_bc1 = sel;
                end
            end
            default: ;
        endcase
    end

    // FSM state, registered bus/handshake outputs and cache valid bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            ready     <= 1'b1;
            done      <= 1'b0;
            rdata     <= 8'h00;
            bdir      <= '0;
            bc1       <= '0;
            bc2       <= '1;
            da_oe     <= 1'b0;
            da_out    <= 8'h00;
            cache_vld <= 4'h0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            ready  <= (nxt_state == S_IDLE);
            done   <= nxt_done;
            rdata  <= nxt_rdata;
            bdir   <= nxt_bdir;
            bc1    <= nxt_bc1;
            bc2    <= '1;
            da_oe  <= nxt_oe;
            da_out <= nxt_dout;
            if (flush)          cache_vld         <= 4'h0;
            else if (latch_end) cache_vld[chip_q] <= 1'b1;
        end
    end

    // Captured request fields and cached addresses; qualified by state/valid bits
    always_ff @(posedge clk) begin
        we_q    <= nxt_we;
        chip_q  <= nxt_chip;
        reg_q   <= nxt_reg;
        wdata_q <= nxt_wdata;
        if (latch_end) cache_addr[chip_q] <= reg_q;
    end

endmodule
